// File: rtl/ahblite_dma_master.sv
// ahblite_dma_master: single-channel memory-to-memory copy engine on an AHB-Lite manager port.
// Each word is moved as a non-pipelined SINGLE read followed by a SINGLE write. No address
// phase overlaps a data phase, so a word costs at least 4 cycles.
//
// Ports
//   HCLK, HRESETn            clock (rising edge), asynchronous active-low reset
//   HADDR/HTRANS/HSIZE/HBURST/HPROT/HWRITE/HWDATA/HMASTLOCK   AHB-Lite manager outputs
//   HREADY/HRDATA/HRESP      AHB-Lite manager inputs
//   start                    one-cycle job request, honoured only when idle
//   src_addr/dst_addr        byte addresses; the low two bits are dropped (word aligned)
//   len                      number of 32-bit words to copy (0 finishes at once)
//   busy                     job in progress
//   done                     one-cycle pulse at the end of a job
//   err                      sticky bus error of the most recent job
//   dma_irq                  interrupt, equal to done
module ahblite_dma_master #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  output logic             HMASTLOCK,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dma_irq
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             err_q, err_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      hwdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      hwdata_q <= hwdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    hwdata_d = hwdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr & 32'hFFFF_FFFC;
          dst_d   = dst_addr & 32'hFFFF_FFFC;
          cnt_d   = len;
          err_d   = 1'b0;
          state_d = (len == '0) ? StFinish : StRdAddr;
        end
      end
      StRdAddr: begin
        if (HREADY) state_d = StRdData;
      end
      StRdData: begin
        // HRESP with HREADY low is just a wait cycle
        if (HREADY) begin
          if (HRESP) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            hold_d  = HRDATA;
            state_d = StWrAddr;
          end
        end
      end
      StWrAddr: begin
        // Load write data on entry so HWDATA is steady for the whole data phase
        if (HREADY) begin
          hwdata_d = hold_q;
          state_d  = StWrData;
        end
      end
      StWrData: begin
        if (HREADY) begin
          if (HRESP) begin
            err_d   = 1'b1;
            state_d = StFinish;
          end else begin
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? StFinish : StRdAddr;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    HTRANS = 2'b00;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    if (state_q == StRdAddr) begin
      HTRANS = 2'b10;
      HADDR  = src_q;
    end else if (state_q == StWrAddr) begin
      HTRANS = 2'b10;
      HADDR  = dst_q;
      HWRITE = 1'b1;
    end
  end

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign dma_irq   = done;
  assign err       = err_q;

endmodule

// File: tb/tb_ahblite_dma_master.sv
module tb_ahblite_dma_master;
  localparam int LEN_W = 16;

  logic             HCLK, HRESETn;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic             HWRITE, HMASTLOCK, HREADY, HRESP;
  logic             start, busy, done, err, dma_irq;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len;

  ahblite_dma_master #(.LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err), .dma_irq(dma_irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Subordinate model: memory, configurable data-phase waits, error on the N-th read
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  int          cfg_waits, cfg_err_rd, done_cnt, hw_unstable;
  logic        dphase, d_write, rd_err, hw_seen;
  logic [31:0] d_addr, hrdata_q, hw_prev;
  int          wcnt;

  assign HREADY = !dphase || (wcnt == 0);
  assign HRESP  = dphase && rd_err;
  assign HRDATA = hrdata_q;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase   <= 1'b0;
      d_write  <= 1'b0;
      d_addr   <= '0;
      wcnt     <= 0;
      rd_err   <= 1'b0;
      hrdata_q <= '0;
      hw_seen  = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (dphase) begin
        if (d_write) begin
          if (hw_seen && HWDATA !== hw_prev) hw_unstable++;
          hw_prev = HWDATA;
          hw_seen = 1'b1;
        end
        if (HREADY) begin
          if (d_write && !HRESP) mem[d_addr] = HWDATA;
          dphase  <= 1'b0;
          rd_err  <= 1'b0;
          hw_seen = 1'b0;
        end else begin
          wcnt <= wcnt - 1;
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        dphase  <= 1'b1;
        d_addr  <= HADDR;
        d_write <= HWRITE;
        wcnt    <= cfg_waits;
        if (HWRITE) begin
          wr_q.push_back(HADDR);
          rd_err <= 1'b0;
        end else begin
          rd_q.push_back(HADDR);
          rd_err   <= (rd_q.size() == cfg_err_rd);
          hrdata_q <= mem.exists(HADDR) ? mem[HADDR] : 32'hDEAD_BEEF;
        end
      end
    end
  end

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          waits;
    int          err_rd;
    bit          restart;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
    logic        exp_err;
    logic [31:0] exp_first_rd;
    logic [31:0] exp_last_rd;
    logic [31:0] exp_first_wr;
  } vec_t;

  task automatic run_job(input vec_t v);
    int cyc;
    logic [31:0] src_al, dst_al;
    src_al = v.src & 32'hFFFF_FFFC;
    dst_al = v.dst & 32'hFFFF_FFFC;
    mem.delete();
    rd_q.delete();
    wr_q.delete();
    done_cnt    = 0;
    hw_unstable = 0;
    cfg_waits   = v.waits;
    cfg_err_rd  = v.err_rd;
    for (int i = 0; i < v.len; i++) mem[src_al + 32'(4 * i)] = 32'(i + 1) * 32'h11;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = LEN_W'(v.len);
    start    = 1'b1;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    cyc   = 1;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    while (!done && cyc < 400) begin
      @(posedge HCLK);
      #1;
      cyc++;
      if (v.restart) begin
        // A second request mid-job must be ignored
        start    = (cyc == 3);
        src_addr = 32'h7000_0000;
        dst_addr = 32'h7000_0100;
        len      = LEN_W'(5);
      end
    end
    start = 1'b0;
    check("done_latency", 32'(cyc), 32'(v.exp_lat));
    check("err", {31'b0, err}, {31'b0, v.exp_err});
    check("dma_irq", {31'b0, dma_irq}, 32'd1);
    @(posedge HCLK);
    #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("read_count", 32'(rd_q.size()), 32'(v.exp_reads));
    check("write_count", 32'(wr_q.size()), 32'(v.exp_writes));
    check("hwdata_stable", 32'(hw_unstable), 32'd0);
    if (v.exp_reads > 0 && rd_q.size() > 0) begin
      check("first_read_addr", rd_q[0], v.exp_first_rd);
      check("last_read_addr", rd_q[rd_q.size()-1], v.exp_last_rd);
    end
    if (v.exp_writes > 0 && wr_q.size() > 0) check("first_write_addr", wr_q[0], v.exp_first_wr);
    for (int i = 0; i < v.exp_writes; i++) begin
      check("dst_data", mem.exists(dst_al + 32'(4 * i)) ? mem[dst_al + 32'(4 * i)] : 32'hBAD0_0000,
            32'(i + 1) * 32'h11);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h2000_0000, 32'h2000_0100, 3, 0, 0, 1'b0, 13, 3, 3, 1'b0,
                32'h2000_0000, 32'h2000_0008, 32'h2000_0100};
    vecs[1] = '{32'h3000_0000, 32'h3000_0100, 1, 2, 0, 1'b0, 9, 1, 1, 1'b0,
                32'h3000_0000, 32'h3000_0000, 32'h3000_0100};
    vecs[2] = '{32'h4000_0000, 32'h4000_0100, 4, 0, 2, 1'b0, 7, 2, 1, 1'b1,
                32'h4000_0000, 32'h4000_0004, 32'h4000_0100};
    vecs[3] = '{32'h0000_0010, 32'h0000_0020, 0, 0, 0, 1'b0, 1, 0, 0, 1'b0,
                32'h0, 32'h0, 32'h0};
    vecs[4] = '{32'hFFFF_FFFC, 32'h5000_0000, 2, 0, 0, 1'b0, 9, 2, 2, 1'b0,
                32'hFFFF_FFFC, 32'h0000_0000, 32'h5000_0000};
    vecs[5] = '{32'h0000_1003, 32'h0000_6002, 1, 0, 0, 1'b0, 5, 1, 1, 1'b0,
                32'h0000_1000, 32'h0000_1000, 32'h0000_6000};
    vecs[6] = '{32'h8000_0000, 32'h8000_0100, 2, 0, 0, 1'b1, 9, 2, 2, 1'b0,
                32'h8000_0000, 32'h8000_0004, 32'h8000_0100};

    HRESETn  = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    cfg_waits = 0;
    cfg_err_rd = 0;
    done_cnt = 0;
    hw_unstable = 0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_htrans", {30'b0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_status", {28'b0, busy, done, err, dma_irq}, 32'd0);
    check("const_ctrl", {19'b0, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK, 1'b0}, {19'b0, 3'b010,
          3'b000, 4'b0011, 1'b0, 1'b0, 1'b0});
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    for (int k = 0; k < 7; k++) run_job(vecs[k]);

    // Reset in the middle of a job: outputs go idle at once, no done, then a fresh job works
    mem.delete();
    rd_q.delete();
    wr_q.delete();
    cfg_waits  = 0;
    cfg_err_rd = 0;
    for (int i = 0; i < 3; i++) mem[32'h2000_0000 + 32'(4 * i)] = 32'(i + 1) * 32'h11;
    src_addr = 32'h2000_0000;
    dst_addr = 32'h2000_0100;
    len      = LEN_W'(3);
    start    = 1'b1;
    @(posedge HCLK);
    #1;
    start    = 1'b0;
    done_cnt = 0;
    repeat (4) @(posedge HCLK);
    #1;
    check("midjob_nonseq", {30'b0, HTRANS}, 32'd2);
    HRESETn = 1'b0;
    #1;
    check("midrst_htrans", {30'b0, HTRANS}, 32'd0);
    check("midrst_haddr", HADDR, 32'd0);
    check("midrst_hwdata", HWDATA, 32'd0);
    check("midrst_status", {28'b0, busy, done, err, dma_irq}, 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_idle", {31'b0, busy}, 32'd0);
    run_job(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ahblite_dma_master.md
AHBLITE_DMA_MASTER -- requirements
Module: ahblite_dma_master

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the word-count field.
REQ-002 SHALL have port HCLK, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port HRESETn, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have AHB-Lite manager outputs: HADDR out 32; HTRANS out 2; HSIZE out 3; HBURST out 3; HPROT out 4; HWRITE out 1; HWDATA out 32; HMASTLOCK out 1.
REQ-005 SHALL have AHB-Lite manager inputs: HREADY in 1; HRDATA in 32; HRESP in 1.
REQ-006 SHALL have command ports: start in 1 (single-cycle request); src_addr in 32; dst_addr in 32; len in LEN_W (word count).
REQ-007 SHALL have status ports: busy out 1; done out 1 (single-cycle pulse); err out 1 (sticky); dma_irq out 1.

Function
REQ-008 SHALL drive constants: HSIZE=3'b010 (word), HBURST=3'b000 (SINGLE), HPROT=4'b0011, HMASTLOCK=0.
REQ-009 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FINISH.
REQ-010 SHALL, in IDLE on start=1, latch src_addr and dst_addr with bits [1:0] forced to 00, latch len into a remaining-count register, clear err, and go to RD_ADDR; if len=0, go to FINISH instead.
REQ-011 SHALL ignore start in every state other than IDLE.
REQ-012 SHALL, in RD_ADDR, drive HTRANS=NONSEQ (2'b10), HWRITE=0, HADDR=current source address; on HREADY=1 go to RD_DATA; otherwise hold all address-phase signals stable.
REQ-013 SHALL, in RD_DATA and WR_DATA, drive HTRANS=IDLE (2'b00); no pipelined address phase overlaps a data phase.
REQ-014 SHALL, in RD_DATA on HREADY=1 and HRESP=0, capture HRDATA into a 32-bit holding register and go to WR_ADDR.
REQ-015 SHALL, in WR_ADDR, drive HTRANS=NONSEQ, HWRITE=1, HADDR=current destination address; on HREADY=1 go to WR_DATA.
REQ-016 SHALL, in WR_DATA, drive HWDATA=holding register for the whole state; on HREADY=1 and HRESP=0, add 4 to both addresses (modulo 2^32, wrap 0xFFFF_FFFC->0x0000_0000) and decrement the count; go to FINISH if the count was 1, otherwise go to RD_ADDR.
REQ-017 SHALL hold HWDATA at its last value outside WR_DATA, and SHALL drive HADDR=0 and HWRITE=0 in IDLE and FINISH.
REQ-018 SHALL treat HRESP=1 with HREADY=0 in a data phase as a wait cycle, and HRESP=1 with HREADY=1 as an error: set err=1, skip the remaining words, go to FINISH.
REQ-019 SHALL, in FINISH, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL assert busy=1 in every state except IDLE.
REQ-021 SHALL assert dma_irq=done, combinationally.
REQ-022 SHALL take each word transfer at least 4 cycles with zero wait states (RD_ADDR, RD_DATA, WR_ADDR, WR_DATA); a len=N job SHALL end with done asserted 4N+1 cycles after the start cycle.
REQ-023 SHALL, when start is accepted, leave err=1 only if an error occurs in the new job.

Reset
REQ-024 SHALL, while HRESETn=0, force: state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, err=0, dma_irq=0, count=0, holding register=0.
REQ-025 SHALL abandon any in-flight job when reset is asserted mid-transfer, with no done pulse; after release, the block is idle and accepts a new start.

Verification
REQ-026 Zero-wait copy: src=0x2000_0000, dst=0x2000_0100, len=3, memory 0x11,0x22,0x33 -> three read/write pairs to ascending addresses, dst holds 0x11,0x22,0x33, done pulses on cycle 13 after start, err=0.
REQ-027 Wait states: HREADY low for 2 cycles in every data phase, len=1 -> HWDATA stable through the waits, single write of the read value, done once.
REQ-028 Error: HRESP=1 on the second read of a len=4 job -> no further HTRANS=NONSEQ, err=1, done pulses once, only 1 write performed.
REQ-029 Corner cases: len=0 gives done one cycle after start with no bus activity; src=0xFFFF_FFFC, len=2 gives a second read at 0x0000_0000; src=0x1003 gives first HADDR 0x1000.
REQ-030 Start while busy is ignored; HRESETn pulsed low mid-job gives immediate idle outputs, no done, and a fresh job afterwards completes correctly.
